dense_layer: RTL and testbench
==============================

# dense_layer

Fully-connected layer engine that sits directly downstream of the UART weight loader. Once the loader reports its transfer complete, the engine reads int8 weights and int32 biases through the loader's synchronous byte read port. It reads uint8 input activations from an external buffer and, for each output neuron, computes bias + Σ w·x. Each neuron result is emitted as a one-cycle 32-bit signed word to the next stage (activation / argmax).

## Interface

Parameters:
- IN_SIZE, 784: inputs per neuron
- OUT_SIZE, 16: neurons in layer
- W_BASE, 0: byte address of weight[0][0]
- B_BASE, 12544: byte address of bias[0]
- ADDR_W, 14: weight memory address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- start  in  1  run request; sampled only in IDLE
- weights_ready  in  1  connected to loader transfer_done
- mem_addr  out  ADDR_W  weight/bias byte address (to loader read_addr)
- mem_data  in  8  byte at mem_addr, valid one cycle after address
- in_addr  out  $clog2(IN_SIZE)  activation index
- in_data  in  8  unsigned activation, valid one cycle after in_addr
- out_valid  out  1  one-cycle strobe, result on out_data
- out_idx  out  $clog2(OUT_SIZE)  neuron index of out_data
- out_data  out  32  signed neuron sum
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last neuron

## Operation

- Memory layout:
  - weight[n][i] at W_BASE + n·IN_SIZE + i, signed int8.
  - bias[n] at B_BASE + 4n .. B_BASE + 4n + 3, little-endian signed int32.
- States:
  - IDLE → BIAS: on start=1 && weights_ready=1. n←0, busy←1.
  - BIAS (5 cycles): issue the 4 bias addresses on cycles 0-3, capture bytes on cycles 1-4. Acc←assembled bias. → MAC.
  - MAC (IN_SIZE+1 cycles): issue mem_addr and in_addr together for i=0..IN_SIZE-1. One cycle later, acc ← acc + sext(w)·zext(x).
  - EMIT (1 cycle): out_valid=1, out_idx=n, out_data=acc. If n==OUT_SIZE-1 → DONE, else n←n+1 → BIAS.
  - DONE (1 cycle): done=1, busy←0 → IDLE.
- Arithmetic: the product is a 17-bit signed value, sign-extended to 32 bits. Accumulation wraps modulo 2^32 with no saturation.
- start is ignored while busy, and ignored when weights_ready=0. weights_ready is checked only at start; deassertion mid-run is ignored.
- mem_addr and in_addr hold their last value in IDLE/EMIT/DONE.
- out_data holds the last result between strobes.

## Timing

- Reset values (rst=0 at an edge):
  - Outputs: mem_addr=0, in_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
  - Internal: state=IDLE, acc=0.
- Reset mid-run aborts immediately. No further out_valid or done is issued; the next start restarts from neuron 0.
- Read latency on mem_data and in_data is exactly 1 cycle; there is no backpressure.
- Let E0 be the edge on which start is accepted. Per-neuron period P = IN_SIZE+7.
  - out_valid for neuron n is high in the cycle after edge E0 + (n+1)·P − 1.
  - done is high one cycle after the last out_valid.
  - busy falls together with done.
- Total run (E0 to done high) is OUT_SIZE·P + 1 cycles; 12657 with default parameters.
- start held high through DONE re-launches a new run on the first IDLE cycle.

## Test plan

All scenarios use IN_SIZE=4, OUT_SIZE=2, W_BASE=0, B_BASE=8, with behavioral byte RAM and activation ROM models of 1-cycle latency.

- Basic run:
  - Stimulus: w0={1,2,3,4}, w1={FF,FF,FF,FF}, bias0=100, bias1=0, x={10,20,30,40}.
  - Required: out_data=400 (idx 0) after E10; 0xFFFFFF9C (idx 1) after E21; done after E22.
- Address sequence:
  - Stimulus: the basic run.
  - Required for neuron 1: mem_addr = 12,13,14,15 then 4,5,6,7; in_addr = 0,1,2,3.
- Gating:
  - Stimulus: start with weights_ready=0.
  - Required: busy stays 0, no out_valid.
  - Stimulus: a second start pulse mid-run.
  - Required: the results and the done cycle are unchanged.
- Extremes/wrap:
  - Stimulus: all weights 0x80, all x=255, bias0=0x80000000.
  - Required: out_data=0x7FFE0200.
- Reset mid-MAC:
  - Stimulus: rst=0 during neuron 0 MAC.
  - Required: all outputs 0 next cycle, no strobe. A fresh start then reproduces the basic-run results.
- Back-to-back runs:
  - Stimulus: start held high.
  - Required: a second identical result sequence starts right after the first done.

Source files
------------

// File: rtl/dense_layer_if.sv
// Bus bundle between the dense-layer engine, its weight/bias byte memory,
// the activation buffer and the downstream result consumer.
interface dense_layer_if #(
   parameter int ADDR_W   = 14,
   parameter int IN_SIZE  = 784,
   parameter int OUT_SIZE = 16
);
   localparam int IN_W  = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
   localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic [IN_W-1:0]   in_addr;
   logic [7:0]        in_data;
   logic              out_valid;
   logic [IDX_W-1:0]  out_idx;
   logic [31:0]       out_data;

   modport master (
      output mem_addr, input mem_data,
      output in_addr,  input in_data,
      output out_valid, output out_idx, output out_data
   );

   modport slave (
      input mem_addr, output mem_data,
      input in_addr,  output in_data,
      input out_valid, input out_idx, input out_data
   );
endinterface

// File: rtl/dense_layer.sv
// Fully-connected layer engine: per neuron, loads a little-endian int32 bias,
// accumulates sext(int8 weight) * zext(uint8 activation), emits the 32-bit sum.
module dense_layer #(
   parameter int IN_SIZE  = 784,
   parameter int OUT_SIZE = 16,
   parameter int W_BASE   = 0,
   parameter int B_BASE   = 12544,
   parameter int ADDR_W   = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          weights_ready,
   dense_layer_if.master bus,
   output logic          busy,
   output logic          done
);
   localparam int IN_W  = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
   localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int CNT_W = ($clog2(IN_SIZE + 1) > 3) ? $clog2(IN_SIZE + 1) : 3;

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_EMIT, S_DONE} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   n;
   logic [IDX_W-1:0]   out_idx;
   logic [ADDR_W-1:0]  b_ptr;
   logic [ADDR_W-1:0]  w_ptr;
   logic [ADDR_W-1:0]  mem_addr;
   logic [IN_W-1:0]    in_addr;
   logic [23:0]        bias_sr;
   logic [31:0]        acc;
   logic [31:0]        acc_sum;
   logic [31:0]        out_data;
   logic signed [16:0] w_ext;
   logic signed [16:0] x_ext;
   logic signed [16:0] prod;
   logic               last_neuron;
   logic               out_valid;

   assign last_neuron = (n == IDX_W'(OUT_SIZE - 1));

   // The product of an int8 and a uint8 always fits in 17 signed bits.
   assign w_ext   = {{9{bus.mem_data[7]}}, bus.mem_data};
   assign x_ext   = {9'b0, bus.in_data};
   assign prod    = w_ext * x_ext;
   assign acc_sum = acc + {{15{prod[16]}}, prod};

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: if (start && weights_ready) state_nxt = S_BIAS;
         S_BIAS: begin
            busy = 1'b1;
            if (cnt == CNT_W'(4)) state_nxt = S_MAC;
         end
         S_MAC: begin
            busy = 1'b1;
            if (cnt == CNT_W'(IN_SIZE)) state_nxt = S_EMIT;
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            state_nxt = last_neuron ? S_DONE : S_BIAS;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (!rst) begin
         cnt      <= '0;
         n        <= '0;
         out_idx  <= '0;
         b_ptr    <= '0;
         w_ptr    <= '0;
         mem_addr <= '0;
         in_addr  <= '0;
         bias_sr  <= '0;
         acc      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            S_IDLE: if (start && weights_ready) begin
               n        <= '0;
               b_ptr    <= ADDR_W'(B_BASE);
               w_ptr    <= ADDR_W'(W_BASE);
               mem_addr <= ADDR_W'(B_BASE);
               cnt      <= '0;
            end
            S_BIAS: begin
               cnt <= cnt + 1'b1;
               if (cnt < CNT_W'(3)) mem_addr <= b_ptr + ADDR_W'(cnt) + ADDR_W'(1);
               // Bytes arrive LSB first; shifting in from the top leaves them in place.
               if (cnt != '0 && cnt != CNT_W'(4)) bias_sr <= {bus.mem_data, bias_sr[23:8]};
               if (cnt == CNT_W'(4)) begin
                  acc      <= {bus.mem_data, bias_sr};
                  mem_addr <= w_ptr;
                  in_addr  <= '0;
                  cnt      <= '0;
               end
            end
            S_MAC: begin
               cnt <= cnt + 1'b1;
               if (cnt < CNT_W'(IN_SIZE - 1)) begin
                  mem_addr <= mem_addr + 1'b1;
                  in_addr  <= in_addr + 1'b1;
               end
               // Cycle 0 still sees the last bias byte on mem_data, so it adds nothing.
               if (cnt != '0) acc <= acc_sum;
               if (cnt == CNT_W'(IN_SIZE)) begin
                  out_data <= acc_sum;
                  out_idx  <= n;
               end
            end
            S_EMIT: if (!last_neuron) begin
               n        <= n + 1'b1;
               b_ptr    <= b_ptr + ADDR_W'(4);
               w_ptr    <= w_ptr + ADDR_W'(IN_SIZE);
               mem_addr <= b_ptr + ADDR_W'(4);
               cnt      <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr  = mem_addr;
   assign bus.in_addr   = in_addr;
   assign bus.out_valid = out_valid;
   assign bus.out_idx   = out_idx;
   assign bus.out_data  = out_data;
endmodule

// File: tb/tb_dense_layer.sv
// Self-checking bench for dense_layer: timing/value model derived from the run
// schedule (E0, period P) compared every cycle, plus hand-computed scenarios.
module tb_dense_layer;
   localparam int IN_SIZE  = 4;
   localparam int OUT_SIZE = 2;
   localparam int W_BASE   = 0;
   localparam int B_BASE   = 8;
   localparam int ADDR_W   = 14;
   localparam int P        = IN_SIZE + 7;
   localparam int RUN      = OUT_SIZE * P;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic weights_ready = 1'b0;
   logic busy, done;

   dense_layer_if #(.ADDR_W(ADDR_W), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus ();

   dense_layer #(
      .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W_BASE(W_BASE),
      .B_BASE(B_BASE), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .weights_ready(weights_ready),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:15];
   logic [7:0] rom [0:IN_SIZE-1];

   // Byte RAM and activation ROM with one cycle of read latency.
   always @(posedge clk) begin
      bus.mem_data <= (bus.mem_addr < 14'd16) ? ram[bus.mem_addr[3:0]] : 8'h00;
      bus.in_data  <= rom[bus.in_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] model_neuron(input int nn);
      int s;
      s = int'({ram[B_BASE+4*nn+3], ram[B_BASE+4*nn+2], ram[B_BASE+4*nn+1], ram[B_BASE+4*nn]});
      for (int i = 0; i < IN_SIZE; i++)
         s = s + int'($signed(ram[W_BASE+nn*IN_SIZE+i])) * int'(rom[i]);
      return 32'(s);
   endfunction

   // Reference model state
   int          edge_cnt = 0;
   int          e0 = 0;
   bit          running = 1'b0;
   bit          checking = 1'b0;
   bit          after_reset = 1'b0;
   logic [31:0] exp_res [OUT_SIZE];
   logic [31:0] hold_data = '0;
   int          hold_idx = 0;

   // Observations
   logic [31:0] obs [$];
   int          obs_rel [$];
   int          obs_edge [$];
   int          done_rel = -1;
   bit          busy_seen = 1'b0;

   int rel, na, c;
   bit exp_busy, exp_done, exp_valid;

   always @(posedge clk) begin
      edge_cnt++;
      if (!rst) begin
         running     = 1'b0;
         hold_data   = '0;
         hold_idx    = 0;
         checking    = 1'b1;
         after_reset = 1'b1;
      end else begin
         if (running && (edge_cnt - e0) > RUN + 1) running = 1'b0;
         if (!running && start && weights_ready) begin
            running = 1'b1;
            e0      = edge_cnt;
            for (int k = 0; k < OUT_SIZE; k++) exp_res[k] = model_neuron(k);
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         rel       = edge_cnt - e0;
         exp_busy  = running && rel < RUN;
         exp_done  = running && rel == RUN;
         exp_valid = running && rel < RUN && ((rel + 1) % P == 0);
         if (exp_valid) begin
            hold_idx  = (rel + 1) / P - 1;
            hold_data = exp_res[hold_idx];
         end
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
         check("out_data", bus.out_data, hold_data);
         check("out_idx", 32'(bus.out_idx), 32'(hold_idx));
         if (running && rel < RUN) begin
            na = rel / P;
            c  = rel % P;
            if (c < 4) begin
               check("mem_addr_bias", 32'(bus.mem_addr), 32'(B_BASE + 4*na + c));
            end else if (c >= 5 && c < 5 + IN_SIZE) begin
               check("mem_addr_w", 32'(bus.mem_addr), 32'(W_BASE + na*IN_SIZE + c - 5));
               check("in_addr", 32'(bus.in_addr), 32'(c - 5));
            end
         end
         if (after_reset) begin
            check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            check("rst_in_addr", 32'(bus.in_addr), 32'd0);
            after_reset = 1'b0;
         end
         if (bus.out_valid) begin
            obs.push_back(bus.out_data);
            obs_rel.push_back(rel);
            obs_edge.push_back(edge_cnt);
         end
         if (busy) busy_seen = 1'b1;
         if (done) done_rel = rel;
      end
   end

   task automatic clear_obs();
      obs.delete();
      obs_rel.delete();
      obs_edge.delete();
      done_rel  = -1;
      busy_seen = 1'b0;
   endtask

   task automatic run_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_basic();
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0] = 8'd1; ram[1] = 8'd2; ram[2] = 8'd3; ram[3] = 8'd4;
      for (int i = 4; i < 8; i++) ram[i] = 8'hFF;
      ram[8] = 8'd100;
      rom[0] = 8'd10; rom[1] = 8'd20; rom[2] = 8'd30; rom[3] = 8'd40;
   endtask

   task automatic check_basic(input string tag);
      check({tag, "_count"}, 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         check({tag, "_n0"}, obs[0], 32'd400);
         check({tag, "_n1"}, obs[1], 32'hFFFFFF9C);
         check({tag, "_n0_time"}, 32'(obs_rel[0]), 32'd10);
         check({tag, "_n1_time"}, 32'(obs_rel[1]), 32'd21);
      end
      check({tag, "_done_time"}, 32'(done_rel), 32'd22);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      for (int i = 0; i < IN_SIZE; i++) rom[i] = 8'h00;
      rst = 1'b0;
      weights_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_data", bus.out_data, 32'd0);
      check("reset_out_idx", 32'(bus.out_idx), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic run
      load_basic();
      check("model_basic_n0", model_neuron(0), 32'd400);
      check("model_basic_n1", model_neuron(1), 32'hFFFFFF9C);
      clear_obs();
      run_pulse();
      repeat (26) @(negedge clk);
      check_basic("basic");

      // Start ignored without weights_ready
      clear_obs();
      weights_ready = 1'b0;
      start = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b0;
      weights_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("gate_busy_seen", 32'(busy_seen), 32'd0);
      check("gate_strobes", 32'(obs.size()), 32'd0);

      // Second start mid-run and weights_ready drop are both ignored
      clear_obs();
      run_pulse();
      repeat (5) @(negedge clk);
      start = 1'b1;
      weights_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      weights_ready = 1'b1;
      repeat (20) @(negedge clk);
      check_basic("restart_ignored");

      // Extremes and wrap-around
      for (int i = 0; i < 8; i++) ram[i] = 8'h80;
      ram[8] = 8'h00; ram[9] = 8'h00; ram[10] = 8'h00; ram[11] = 8'h80;
      for (int i = 12; i < 16; i++) ram[i] = 8'h00;
      for (int i = 0; i < IN_SIZE; i++) rom[i] = 8'hFF;
      check("model_ext_n0", model_neuron(0), 32'h7FFE0200);
      clear_obs();
      run_pulse();
      repeat (26) @(negedge clk);
      check("ext_count", 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         check("ext_n0", obs[0], 32'h7FFE0200);
         check("ext_n1", obs[1], 32'hFFFE0200);
      end

      // Reset during neuron 0 MAC
      load_basic();
      clear_obs();
      run_pulse();
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_data", bus.out_data, 32'd0);
      check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      check("midrst_strobes", 32'(obs.size()), 32'd0);
      check("midrst_done", 32'(done_rel), 32'hFFFFFFFF);
      clear_obs();
      run_pulse();
      repeat (26) @(negedge clk);
      check_basic("after_reset");

      // Back-to-back runs with start held high
      clear_obs();
      start = 1'b1;
      repeat (50) @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("b2b_count", 32'(obs.size()), 32'd6);
      if (obs.size() >= 4) begin
         check("b2b_run2_n0", obs[2], 32'd400);
         check("b2b_run2_n1", obs[3], 32'hFFFFFF9C);
         check("b2b_gap", 32'(obs_edge[2] - obs_edge[0]), 32'd24);
      end

      // Randomized contents, checked cycle by cycle against the model
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
         for (int i = 0; i < IN_SIZE; i++) rom[i] = 8'($urandom);
         clear_obs();
         run_pulse();
         repeat ($urandom_range(4, 15)) @(negedge clk);
         weights_ready = 1'($urandom);
         repeat (14) @(negedge clk);
         weights_ready = 1'b1;
         check("rand_count", 32'(obs.size()), 32'd2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
